uart_alu: RTL and testbench
===========================

// Module: uart_alu
// PURPOSE
//  - UART-attached 32-bit ALU: receives command packets on rx_i, executes them, returns results on tx_o.
//  - Contains 8N1 UART receiver, packet parser/FSM, ALU datapath and 8N1 UART transmitter.
//  - Top-level serial endpoint of the UART ALU design; the host (or bench runner) talks to it byte-wise.
// PARAMETERS
//  - CLK_FREQ_HZ  default 100_000_000  system clock frequency
//  - BAUD_RATE    default 115_200      UART bit rate; CLKS_PER_BIT = CLK_FREQ_HZ/BAUD_RATE (integer division)
// PORTS
//  - clk_i   in   1  system clock, all logic on rising edge
//  - rst_i   in   1  reset, asynchronous, active-high
//  - rx_i    in   1  UART serial input, idle high, 8N1, LSB first
//  - tx_o    out  1  UART serial output, idle high, 8N1, LSB first
//  - busy_o  out  1  high while a packet is being received, executed or transmitted
// BEHAVIOUR
//  - Reset: tx_o=1, busy_o=0, FSM=IDLE, byte/length counters and accumulator cleared.
//  - rx_i passes a 2-flop synchronizer; start bit detected on falling edge, re-checked at mid-bit
//    (CLKS_PER_BIT/2); glitch (high at mid-bit) ignored. Data sampled at bit centres.
//  - Stop bit sampled low -> framing error: byte discarded, parser state unchanged.
//  - Packet: byte0 opcode, byte1 reserved (ignored), byte2 LEN[7:0], byte3 LEN[15:8],
//    then LEN-4 payload bytes; LEN counts the whole packet including header.
//  - Payload = sequence of 32-bit operands, little-endian, 4 bytes each.
//  - Opcodes: 0xEC ECHO (each payload byte retransmitted as received);
//    0x10 ADD32 (wrapping sum of all operands); 0x11 MUL32 (see CONFIGURATION).
//  - FSM: IDLE->OPCODE->RESERVED->LEN_LO->LEN_HI->PAYLOAD->(RESULT_TX for ALU ops)->IDLE.
//  - ALU ops: accumulator loaded with first operand, next operands combined on completion
//    of their 4th byte; after last payload byte, 32-bit result sent LSB first (4 bytes).
//  - Unknown opcode, or LEN<4: remaining LEN-4 bytes (if any) consumed and dropped, no response.
//  - ALU op with LEN-4 not a multiple of 4: trailing partial operand ignored.
//  - ALU op with zero operands (LEN==4): result 0x00000000 transmitted.
//  - Incomplete packet: FSM waits indefinitely in PAYLOAD; no timeout, nothing transmitted.
//  - Bytes received during RESULT_TX are dropped; busy_o stays high until last stop bit ends.
//  - TX: 1-byte holding register; next byte starts the cycle after previous stop bit completes.
//  - Reset mid-operation aborts immediately: tx_o forced high that cycle, FSM to IDLE.
// CONFIGURATION
//  - UART_ALU_MUL_EN defined: opcode 0x11 MUL32 enabled, result = low 32 bits of product of
//    all operands (single-cycle or iterative multiplier, done before RESULT_TX starts).
//  - UART_ALU_MUL_EN undefined: 0x11 treated as unknown opcode (packet consumed, no response).
// TESTING
//  - Reset held then released -> tx_o=1, busy_o=0, no TX activity while rx_i idle.
//  - Send EC 00 06 00 AB CD -> tx_o emits AB, CD.
//  - Send 10 00 0C 00 01 00 00 00 02 00 00 00 -> tx_o emits 03 00 00 00.
//  - Send 10 01 30 24 11 -> no TX output, busy_o remains high (awaits 0x2430-byte packet).
//  - Send 11 00 0C 00 03 00 00 00 05 00 00 00 -> with UART_ALU_MUL_EN: 0F 00 00 00;
//    without: no output, FSM back in IDLE afterward.
//  - Byte with stop bit forced low -> byte dropped; following valid EC 00 05 00 5A echoes 5A.

Source files
------------

// File: rtl/uart_alu.sv
// uart_alu: UART-attached 32-bit ALU.
//   Receives command packets as 8N1 bytes on rx_i and parses them:
//     opcode, reserved, LEN lo, LEN hi, then LEN-4 payload bytes.
//   Executes the command and returns any result as 8N1 bytes on tx_o.
//   Opcodes:
//     0xEC ECHO  - each payload byte is sent back as it arrives.
//     0x10 ADD32 - wrapping sum of all little-endian 32-bit operands.
//     0x11 MUL32 - low 32 bits of the product of all operands. Only
//                  when UART_ALU_MUL_EN is defined; otherwise 0x11 is
//                  handled like any unknown opcode.
// Parameters:
//   CLK_FREQ_HZ - system clock frequency.
//   BAUD_RATE   - UART bit rate; CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE.
// Ports:
//   clk_i  - system clock, rising edge
//   rst_i  - asynchronous active-high reset
//   rx_i   - UART serial in, idle high
//   tx_o   - UART serial out, idle high
//   busy_o - high while a packet is received, executed or transmitted
module uart_alu #(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int BAUD_RATE   = 115_200
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic rx_i,
  output logic tx_o,
  output logic busy_o
);

  localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CW           = $clog2(CLKS_PER_BIT + 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {P_IDLE, P_OPCODE, P_RESERVED, P_LEN_LO,
                            P_LEN_HI, P_PAYLOAD, P_RESULT_TX} p_state_t;
  typedef enum logic [1:0] {OP_ECHO, OP_ADD, OP_MUL, OP_DROP} op_t;

  // Receiver state
  logic          rx_meta_q, rx_sync_q, rx_prev_q;
  rx_state_t     rx_state_q;
  logic [CW-1:0] rx_cnt_q;
  logic [2:0]    rx_bit_q;
  logic [7:0]    rx_shift_q;
  logic          rx_valid_q;
  logic [7:0]    rx_byte_q;

  // Parser / ALU state
  p_state_t      p_state_q;
  op_t           op_q;
  logic [7:0]    opcode_q;
  logic [7:0]    len_lo_q;
  logic [15:0]   rem_q;
  logic [1:0]    byte_idx_q;
  logic [23:0]   opnd_q;
  logic          first_q;
  logic [31:0]   acc_q;
  logic [2:0]    res_cnt_q;
  logic          push_q;
  logic [7:0]    push_data_q;

  // Transmitter state
  logic          tx_q;
  logic          tx_active_q;
  logic [8:0]    tx_frame_q;
  logic [3:0]    tx_bit_q;
  logic [CW-1:0] tx_cnt_q;
  logic [7:0]    hold_q;
  logic          hold_v_q;
  logic          busy_q;

  logic [15:0]   len_full_s;
  logic [31:0]   operand_s;
  logic [31:0]   combined_s;

  assign len_full_s = {rx_byte_q, len_lo_q};
  // Completed operand: the byte arriving now is the most significant one.
  assign operand_s  = {rx_byte_q, opnd_q};
  assign tx_o       = tx_q;
  assign busy_o     = busy_q;

  // ALU combine of accumulator with a freshly completed operand
  always_comb begin
    combined_s = acc_q + operand_s;
`ifdef UART_ALU_MUL_EN
    if (op_q == OP_MUL) begin
      combined_s = acc_q * operand_s;
    end else begin
      combined_s = acc_q + operand_s;
    end
`endif
  end

  // Two-flop synchronizer plus previous-sample flop for edge detection
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rx_i;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  // 8N1 receiver: start confirmed at mid-bit, data and stop sampled at bit centres
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= 3'd0;
      rx_shift_q <= 8'd0;
      rx_valid_q <= 1'b0;
      rx_byte_q  <= 8'd0;
    end else begin
      rx_valid_q <= 1'b0;
      case (rx_state_q)
        RX_IDLE: begin
          rx_cnt_q <= '0;
          if (rx_prev_q && !rx_sync_q) begin
            rx_state_q <= RX_START;
          end
        end
        RX_START: begin
          if (rx_cnt_q == CW'(HALF_BIT - 1)) begin
            rx_cnt_q <= '0;
            rx_bit_q <= 3'd0;
            // A line already back high at mid-bit was only a glitch.
            rx_state_q <= rx_sync_q ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt_q <= rx_cnt_q + CW'(1);
          end
        end
        RX_DATA: begin
          if (rx_cnt_q == CW'(CLKS_PER_BIT - 1)) begin
            rx_cnt_q   <= '0;
            rx_shift_q <= {rx_sync_q, rx_shift_q[7:1]};
            if (rx_bit_q == 3'd7) begin
              rx_state_q <= RX_STOP;
            end else begin
              rx_bit_q <= rx_bit_q + 3'd1;
            end
          end else begin
            rx_cnt_q <= rx_cnt_q + CW'(1);
          end
        end
        RX_STOP: begin
          if (rx_cnt_q == CW'(CLKS_PER_BIT - 1)) begin
            rx_cnt_q   <= '0;
            rx_state_q <= RX_IDLE;
            // A low stop bit is a framing error: the byte is never delivered.
            if (rx_sync_q) begin
              rx_valid_q <= 1'b1;
              rx_byte_q  <= rx_shift_q;
            end
          end else begin
            rx_cnt_q <= rx_cnt_q + CW'(1);
          end
        end
        default: rx_state_q <= RX_IDLE;
      endcase
    end
  end

  // Packet parser, accumulator and result sequencer
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      p_state_q   <= P_IDLE;
      op_q        <= OP_DROP;
      opcode_q    <= 8'd0;
      len_lo_q    <= 8'd0;
      rem_q       <= 16'd0;
      byte_idx_q  <= 2'd0;
      opnd_q      <= 24'd0;
      first_q     <= 1'b1;
      acc_q       <= 32'd0;
      res_cnt_q   <= 3'd0;
      push_q      <= 1'b0;
      push_data_q <= 8'd0;
    end else begin
      push_q <= 1'b0;
      case (p_state_q)
        P_IDLE: begin
          if (rx_valid_q) begin
            opcode_q  <= rx_byte_q;
            p_state_q <= P_OPCODE;
          end
        end
        P_OPCODE: begin
          case (opcode_q)
            8'hEC:   op_q <= OP_ECHO;
            8'h10:   op_q <= OP_ADD;
`ifdef UART_ALU_MUL_EN
            8'h11:   op_q <= OP_MUL;
`endif
            default: op_q <= OP_DROP;
          endcase
          acc_q      <= 32'd0;
          first_q    <= 1'b1;
          byte_idx_q <= 2'd0;
          res_cnt_q  <= 3'd0;
          p_state_q  <= P_RESERVED;
        end
        P_RESERVED: begin
          if (rx_valid_q) begin
            p_state_q <= P_LEN_LO;
          end
        end
        P_LEN_LO: begin
          if (rx_valid_q) begin
            len_lo_q  <= rx_byte_q;
            p_state_q <= P_LEN_HI;
          end
        end
        P_LEN_HI: begin
          if (rx_valid_q) begin
            rem_q <= len_full_s - 16'd4;
            if (len_full_s < 16'd4) begin
              p_state_q <= P_IDLE;
            end else if (len_full_s == 16'd4) begin
              // No payload: ALU ops still answer with the cleared accumulator.
              p_state_q <= (op_q == OP_ADD || op_q == OP_MUL) ? P_RESULT_TX : P_IDLE;
            end else begin
              p_state_q <= P_PAYLOAD;
            end
          end
        end
        P_PAYLOAD: begin
          if (rx_valid_q) begin
            rem_q      <= rem_q - 16'd1;
            opnd_q     <= {rx_byte_q, opnd_q[23:8]};
            byte_idx_q <= byte_idx_q + 2'd1;
            if (op_q == OP_ECHO) begin
              push_q      <= 1'b1;
              push_data_q <= rx_byte_q;
            end
            if (byte_idx_q == 2'd3) begin
              acc_q   <= first_q ? operand_s : combined_s;
              first_q <= 1'b0;
            end
            if (rem_q == 16'd1) begin
              p_state_q <= (op_q == OP_ADD || op_q == OP_MUL) ? P_RESULT_TX : P_IDLE;
            end
          end
        end
        P_RESULT_TX: begin
          // Incoming bytes are ignored here; result goes out LSB first.
          if (res_cnt_q != 3'd4) begin
            if (!push_q && !hold_v_q) begin
              push_q      <= 1'b1;
              push_data_q <= 8'(acc_q >> {res_cnt_q[1:0], 3'b000});
              res_cnt_q   <= res_cnt_q + 3'd1;
            end
          end else if (!push_q && !hold_v_q && !tx_active_q) begin
            p_state_q <= P_IDLE;
          end
        end
        default: p_state_q <= P_IDLE;
      endcase
    end
  end

  // 8N1 transmitter with a one-byte holding register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tx_q        <= 1'b1;
      tx_active_q <= 1'b0;
      tx_frame_q  <= 9'h1FF;
      tx_bit_q    <= 4'd0;
      tx_cnt_q    <= '0;
      hold_q      <= 8'd0;
      hold_v_q    <= 1'b0;
    end else begin
      // A push in the same cycle as a load refills the register behind it.
      if (push_q) begin
        hold_q   <= push_data_q;
        hold_v_q <= 1'b1;
      end else if (!tx_active_q && hold_v_q) begin
        hold_v_q <= 1'b0;
      end
      if (!tx_active_q) begin
        if (hold_v_q) begin
          tx_active_q <= 1'b1;
          tx_q        <= 1'b0;
          tx_frame_q  <= {1'b1, hold_q};
          tx_bit_q    <= 4'd0;
          tx_cnt_q    <= '0;
        end
      end else if (tx_cnt_q == CW'(CLKS_PER_BIT - 1)) begin
        tx_cnt_q <= '0;
        // Bit 9 is the stop bit; the frame ends when it has been held a full bit.
        if (tx_bit_q == 4'd9) begin
          tx_active_q <= 1'b0;
        end else begin
          tx_q       <= tx_frame_q[0];
          tx_frame_q <= {1'b1, tx_frame_q[8:1]};
          tx_bit_q   <= tx_bit_q + 4'd1;
        end
      end else begin
        tx_cnt_q <= tx_cnt_q + CW'(1);
      end
    end
  end

  // Busy flag: any receive, parse or transmit activity in flight
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      busy_q <= 1'b0;
    end else begin
      busy_q <= (rx_state_q != RX_IDLE) || (p_state_q != P_IDLE) ||
                push_q || hold_v_q || tx_active_q;
    end
  end

endmodule

// File: tb/tb_uart_alu.sv
module tb_uart_alu;
  localparam int CPB = 16;
`ifdef UART_ALU_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  logic rx_i  = 1'b1;
  logic tx_o;
  logic busy_o;

  int checks = 0;
  int errors = 0;

  logic [7:0] pkt[$];
  logic [7:0] mdl_q[$];
  logic [7:0] exp_q[$];

  uart_alu #(.CLK_FREQ_HZ(16), .BAUD_RATE(1)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .rx_i  (rx_i),
    .tx_o  (tx_o),
    .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  // Reference: response bytes of the packet in pkt, from the packet rules alone.
  task automatic run_model();
    int len, npay, avail, nops;
    logic [31:0] acc, opnd;
    logic [7:0] opc;
    mdl_q.delete();
    if (pkt.size() < 4) return;
    opc   = pkt[0];
    len   = int'({pkt[3], pkt[2]});
    if (len < 4) return;
    npay  = len - 4;
    avail = pkt.size() - 4;
    if (opc == 8'hEC) begin
      for (int i = 0; i < npay && i < avail; i++) mdl_q.push_back(pkt[4 + i]);
      return;
    end
    if (!(opc == 8'h10 || (MUL_EN && opc == 8'h11))) return;
    if (avail < npay) return;
    nops = npay / 4;
    acc  = (opc == 8'h10) ? 32'd0 : 32'd1;
    for (int k = 0; k < nops; k++) begin
      opnd = {pkt[4*k+7], pkt[4*k+6], pkt[4*k+5], pkt[4*k+4]};
      acc  = (opc == 8'h10) ? acc + opnd : acc * opnd;
    end
    if (nops == 0) acc = 32'd0;
    for (int i = 0; i < 4; i++) mdl_q.push_back(acc[8*i +: 8]);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx_i = 1'b0;
    repeat (CPB) @(negedge clk_i);
    for (int i = 0; i < 8; i++) begin
      rx_i = b[i];
      repeat (CPB) @(negedge clk_i);
    end
    rx_i = stop;
    repeat (CPB) @(negedge clk_i);
    rx_i = 1'b1;
  endtask

  task automatic send_pkt();
    for (int i = 0; i < pkt.size(); i++) send_byte(pkt[i], 1'b1);
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while ((exp_q.size() != 0 || busy_o) && n < 6000) begin
      @(negedge clk_i);
      n++;
    end
    chk({nm, "_timeout"}, 32'(n < 6000), 32'd1);
    chk({nm, "_busy_end"}, 32'(busy_o), 32'd0);
    chk({nm, "_tx_idle"}, 32'(tx_o), 32'd1);
  endtask

  task automatic do_pkt(input string nm);
    run_model();
    for (int i = 0; i < mdl_q.size(); i++) exp_q.push_back(mdl_q[i]);
    send_pkt();
    wait_idle(nm);
  endtask

  // Serial decoder on tx_o compared byte-by-byte with the expected stream
  initial begin
    logic [7:0] d;
    forever begin
      @(negedge clk_i);
      if (tx_o === 1'b0 && !rst_i) begin
        repeat (CPB/2) @(negedge clk_i);
        chk("tx_start_bit", 32'(tx_o), 32'd0);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk_i);
          d[i] = tx_o;
        end
        repeat (CPB) @(negedge clk_i);
        chk("tx_stop_bit", 32'(tx_o), 32'd1);
        if (exp_q.size() == 0) begin
          chk("tx_unexpected_byte", 32'(d), 32'hFFFF_FFFF);
        end else begin
          chk("tx_byte", 32'(d), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    // Reset state
    repeat (5) @(negedge clk_i);
    chk("rst_tx", 32'(tx_o), 32'd1);
    chk("rst_busy", 32'(busy_o), 32'd0);
    rst_i = 1'b0;
    repeat (20*CPB) @(negedge clk_i);
    chk("idle_tx", 32'(tx_o), 32'd1);
    chk("idle_busy", 32'(busy_o), 32'd0);

    // Hand-computed pins on the model
    pkt = '{8'hEC, 8'h00, 8'h06, 8'h00, 8'hAB, 8'hCD};
    run_model();
    chk("pin_echo_n", 32'(mdl_q.size()), 32'd2);
    chk("pin_echo_b0", 32'(mdl_q[0]), 32'hAB);
    chk("pin_echo_b1", 32'(mdl_q[1]), 32'hCD);
    pkt = '{8'h10, 8'h00, 8'h0C, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00};
    run_model();
    chk("pin_add_n", 32'(mdl_q.size()), 32'd4);
    chk("pin_add_v", {mdl_q[3], mdl_q[2], mdl_q[1], mdl_q[0]}, 32'h0000_0003);
    pkt = '{8'h11, 8'h00, 8'h0C, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00};
    run_model();
    chk("pin_mul_n", 32'(mdl_q.size()), MUL_EN ? 32'd4 : 32'd0);
    if (MUL_EN) chk("pin_mul_v", {mdl_q[3], mdl_q[2], mdl_q[1], mdl_q[0]}, 32'h0000_000F);

    // Directed packets against the DUT
    pkt = '{8'hEC, 8'h00, 8'h06, 8'h00, 8'hAB, 8'hCD};
    do_pkt("echo");
    pkt = '{8'h10, 8'h00, 8'h0C, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00};
    do_pkt("add");
    pkt = '{8'h10, 8'h00, 8'h10, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
            8'h02, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00};
    do_pkt("add_wrap");
    pkt = '{8'h10, 8'h00, 8'h0A, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h77, 8'h88};
    do_pkt("add_partial");
    pkt = '{8'h10, 8'h00, 8'h04, 8'h00};
    do_pkt("add_zero_ops");
    pkt = '{8'h11, 8'h00, 8'h0C, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00};
    do_pkt("mul");
    pkt = '{8'h22, 8'h00, 8'h06, 8'h00, 8'h11, 8'h22};
    do_pkt("unknown_op");
    pkt = '{8'hEC, 8'h00, 8'h02, 8'h00};
    do_pkt("short_len");

    // Framing error: byte dropped, following echo still works
    send_byte(8'hEC, 1'b0);
    repeat (2*CPB) @(negedge clk_i);
    pkt = '{8'hEC, 8'h00, 8'h05, 8'h00, 8'h5A};
    do_pkt("after_framing");

    // Short low glitch on rx is ignored
    rx_i = 1'b0;
    repeat (3) @(negedge clk_i);
    rx_i = 1'b1;
    repeat (2*CPB) @(negedge clk_i);
    pkt = '{8'hEC, 8'h00, 8'h05, 8'h00, 8'hA5};
    do_pkt("after_glitch");

    // Byte arriving during result transmission is dropped
    pkt = '{8'h10, 8'h00, 8'h08, 8'h00, 8'h07, 8'h00, 8'h00, 8'h00};
    run_model();
    for (int i = 0; i < mdl_q.size(); i++) exp_q.push_back(mdl_q[i]);
    send_pkt();
    send_byte(8'hEC, 1'b1);
    wait_idle("drop_in_tx");
    pkt = '{8'hEC, 8'h00, 8'h05, 8'h00, 8'h3C};
    do_pkt("after_drop");

    // Incomplete packet: waits with busy high, then reset aborts it
    pkt = '{8'h10, 8'h01, 8'h30, 8'h24, 8'h11};
    send_pkt();
    repeat (40*CPB) @(negedge clk_i);
    chk("incomplete_busy", 32'(busy_o), 32'd1);
    chk("incomplete_tx", 32'(tx_o), 32'd1);
    rst_i = 1'b1;
    @(negedge clk_i);
    chk("midrst_tx", 32'(tx_o), 32'd1);
    chk("midrst_busy", 32'(busy_o), 32'd0);
    rst_i = 1'b0;
    repeat (2*CPB) @(negedge clk_i);
    pkt = '{8'hEC, 8'h00, 8'h06, 8'h00, 8'h12, 8'h34};
    do_pkt("after_reset");

    repeat (4*CPB) @(negedge clk_i);
    chk("exp_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
